// File: rtl/unary_a_streamer.sv
// unary_a_streamer: buffers one binary A matrix row-by-row, then replays it as
// column-skewed unary bitstreams with a per-frame strobe for the systolic array.
module unary_a_streamer #(
    parameter int SIZE        = 4,
    parameter int A_ROW       = 2,
    parameter int A_COL       = 2,
    parameter int TAIL_FRAMES = 3,
    localparam int FRAME_LEN  = (32'd1 << SIZE) + 2,
    localparam int NUM_FRAMES = A_ROW + A_COL - 1 + TAIL_FRAMES,
    localparam int FI_W       = $clog2(NUM_FRAMES + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A_COL*SIZE-1:0] in_row,
    output logic [A_COL-1:0]      unary_out,
    output logic                  frame_start,
    output logic [FI_W-1:0]       frame_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int ROW_W = (A_ROW > 1) ? $clog2(A_ROW) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(A_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(32'd1);
    localparam logic [SIZE:0]    CYC_LAST = (SIZE + 1)'(FRAME_LEN - 1);
    localparam logic [SIZE:0]    CYC_ONE  = (SIZE + 1)'(32'd1);
    localparam logic [FI_W-1:0]  FI_LAST  = FI_W'(NUM_FRAMES - 1);
    localparam logic [FI_W-1:0]  FI_ONE   = FI_W'(32'd1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef logic [A_ROW-1:0][A_COL*SIZE-1:0] buf_t;

    state_t           state_r;
    state_t           state_s;
    logic [ROW_W-1:0] row_cnt_r;
    logic [ROW_W-1:0] row_cnt_s;
    logic [SIZE:0]    cyc_r;
    logic [SIZE:0]    cyc_s;
    logic [FI_W-1:0]  fidx_r;
    logic [FI_W-1:0]  fidx_s;
    buf_t             buf_r;
    buf_t             buf_s;
    logic [A_COL-1:0] lane_s;

    logic             in_ready_r;
    logic [A_COL-1:0] unary_r;
    logic             frame_start_r;
    logic [FI_W-1:0]  frame_idx_r;
    logic             busy_r;
    logic             done_r;

    // Next-state logic: row capture in LOAD, frame/cycle counting in STREAM.
    always_comb begin
        state_s   = state_r;
        row_cnt_s = row_cnt_r;
        cyc_s     = cyc_r;
        fidx_s    = fidx_r;
        buf_s     = buf_r;
        case (state_r)
            ST_LOAD: begin
                if (in_valid) begin
                    buf_s[row_cnt_r] = in_row;
                    if (row_cnt_r == ROW_LAST) begin
                        state_s   = ST_STREAM;
                        row_cnt_s = {ROW_W{1'b0}};
                        cyc_s     = {(SIZE + 1){1'b0}};
                        fidx_s    = {FI_W{1'b0}};
                    end else begin
                        row_cnt_s = row_cnt_r + ROW_ONE;
                    end
                end else begin
                    row_cnt_s = row_cnt_r;
                end
            end
            ST_STREAM: begin
                if (cyc_r == CYC_LAST) begin
                    cyc_s = {(SIZE + 1){1'b0}};
                    if (fidx_r == FI_LAST) begin
                        state_s = ST_DONE;
                        fidx_s  = {FI_W{1'b0}};
                    end else begin
                        fidx_s = fidx_r + FI_ONE;
                    end
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            ST_DONE: begin
                state_s   = ST_LOAD;
                row_cnt_s = {ROW_W{1'b0}};
            end
            default: begin
                state_s   = ST_LOAD;
                row_cnt_s = {ROW_W{1'b0}};
                cyc_s     = {(SIZE + 1){1'b0}};
                fidx_s    = {FI_W{1'b0}};
            end
        endcase
    end

    // Lane decode for the upcoming cycle: lane j carries row (frame - j).
    always_comb begin
        lane_s = {A_COL{1'b0}};
        for (int j = 0; j < A_COL; j++) begin
            for (int r = 0; r < A_ROW; r++) begin
                lane_s[j] = lane_s[j]
                          | ((int'(fidx_s) == (r + j))
                             && (cyc_s < {1'b0, buf_s[r][j*SIZE +: SIZE]}));
            end
        end
    end

    // Control state and matrix buffer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_LOAD;
            row_cnt_r <= {ROW_W{1'b0}};
            cyc_r     <= {(SIZE + 1){1'b0}};
            fidx_r    <= {FI_W{1'b0}};
            buf_r     <= {(A_ROW * A_COL * SIZE){1'b0}};
        end else begin
            state_r   <= state_s;
            row_cnt_r <= row_cnt_s;
            cyc_r     <= cyc_s;
            fidx_r    <= fidx_s;
            buf_r     <= buf_s;
        end
    end

    // Outputs registered from next state so they line up with the state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r    <= 1'b1;
            unary_r       <= {A_COL{1'b0}};
            frame_start_r <= 1'b0;
            frame_idx_r   <= {FI_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            in_ready_r    <= (state_s == ST_LOAD);
            busy_r        <= (state_s == ST_STREAM);
            done_r        <= (state_s == ST_DONE);
            frame_start_r <= (state_s == ST_STREAM) && (cyc_s == {(SIZE + 1){1'b0}});
            frame_idx_r   <= (state_s == ST_STREAM) ? fidx_s : {FI_W{1'b0}};
            unary_r       <= (state_s == ST_STREAM) ? lane_s : {A_COL{1'b0}};
        end
    end

    assign in_ready    = in_ready_r;
    assign unary_out   = unary_r;
    assign frame_start = frame_start_r;
    assign frame_idx   = frame_idx_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_unary_a_streamer.sv
// Directed bench for unary_a_streamer: default 4/2/2/3 instance plus a
// SIZE=2, A_ROW=3, A_COL=1, TAIL_FRAMES=0 instance.
module tb_unary_a_streamer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;

    logic       in_valid = 1'b0;
    logic [7:0] in_row = 8'h00;
    logic       in_ready;
    logic [1:0] unary_out;
    logic       frame_start;
    logic [2:0] frame_idx;
    logic       busy;
    logic       done;

    logic       sw_in_valid = 1'b0;
    logic [1:0] sw_in_row = 2'd0;
    logic       sw_in_ready;
    logic [0:0] sw_unary;
    logic       sw_frame_start;
    logic [1:0] sw_frame_idx;
    logic       sw_busy;
    logic       sw_done;

    int n_checks = 0;
    int n_err    = 0;

    int sw_cnt [3];
    int sw_hi  [3];
    int sw_fs_cnt;
    int sw_bad;
    int sf;
    int sk;

    always #5 clk = ~clk;

    unary_a_streamer u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .unary_out   (unary_out),
        .frame_start (frame_start),
        .frame_idx   (frame_idx),
        .busy        (busy),
        .done        (done)
    );

    unary_a_streamer #(.SIZE(2), .A_ROW(3), .A_COL(1), .TAIL_FRAMES(0)) u_sw (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (sw_in_valid),
        .in_ready    (sw_in_ready),
        .in_row      (sw_in_row),
        .unary_out   (sw_unary),
        .frame_start (sw_frame_start),
        .frame_idx   (sw_frame_idx),
        .busy        (sw_busy),
        .done        (sw_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples a whole 108-cycle stream starting at its first cycle; per-frame
    // expected ones counts are given per lane, frame f at bits [f*8 +: 8].
    task automatic stream_check(input string name, input logic [47:0] exp0, input logic [47:0] exp1);
        int cnt [6][2];
        int hi  [6][2];
        int fs_cnt;
        int bad_fs;
        int bad_fi;
        int bad_ctl;
        int f;
        int k;
        logic [47:0] e;
        fs_cnt = 0; bad_fs = 0; bad_fi = 0; bad_ctl = 0;
        for (int a = 0; a < 6; a++) begin
            for (int b = 0; b < 2; b++) begin
                cnt[a][b] = 0;
                hi[a][b]  = 0;
            end
        end
        for (int c = 0; c < 108; c++) begin
            f = c / 18;
            k = c % 18;
            for (int j = 0; j < 2; j++) begin
                if (unary_out[j] === 1'b1) begin
                    cnt[f][j]++;
                    hi[f][j] = k + 1;
                end
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (frame_start !== (k == 0)) bad_fs++;
            if (frame_idx !== 3'(f)) bad_fi++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) bad_ctl++;
            step();
        end
        for (int a = 0; a < 6; a++) begin
            for (int j = 0; j < 2; j++) begin
                e = (j == 0) ? exp0 : exp1;
                chk($sformatf("%s f%0d lane%0d ones", name, a, j), cnt[a][j], 32'(e[a*8 +: 8]));
                chk($sformatf("%s f%0d lane%0d run_end", name, a, j), hi[a][j], 32'(e[a*8 +: 8]));
            end
        end
        chk({name, " frame_start count"}, fs_cnt, 32'd6);
        chk({name, " frame_start spacing"}, bad_fs, 32'd0);
        chk({name, " frame_idx"}, bad_fi, 32'd0);
        chk({name, " stream ctl"}, bad_ctl, 32'd0);
        chk({name, " done"}, done, 32'd1);
        chk({name, " done busy"}, busy, 32'd0);
        chk({name, " done in_ready"}, in_ready, 32'd0);
        chk({name, " done unary"}, unary_out, 32'd0);
    endtask

    initial begin
        // Reset values
        #1 reset_n = 1'b0;
        #3;
        chk("rst in_ready", in_ready, 32'd1);
        chk("rst unary", unary_out, 32'd0);
        chk("rst frame_start", frame_start, 32'd0);
        chk("rst busy", busy, 32'd0);
        chk("rst done", done, 32'd0);
        chk("rst frame_idx", frame_idx, 32'd0);
        chk("rst sw in_ready", sw_in_ready, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Matrix 1 {3,5},{15,0} with in_valid pattern 1,0,0,1
        in_valid = 1'b1;
        in_row   = 8'h53;
        step();
        chk("gap after beat0 busy", busy, 32'd0);
        chk("gap after beat0 in_ready", in_ready, 32'd1);
        in_valid = 1'b0;
        step();
        step();
        chk("gap idle busy", busy, 32'd0);
        in_valid = 1'b1;
        in_row   = 8'h0F;
        step();
        chk("m1 first busy", busy, 32'd1);
        chk("m1 first frame_start", frame_start, 32'd1);
        chk("m1 first unary", unary_out, 32'd1);
        chk("m1 first in_ready", in_ready, 32'd0);
        in_row = 8'h99;
        stream_check("m1", {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd3},
                           {8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0});

        // Matrix 2 all 15, in_valid already high from the DONE cycle
        in_row = 8'hFF;
        step();
        chk("m2 load in_ready", in_ready, 32'd1);
        chk("m2 done single", done, 32'd0);
        chk("m2 load busy", busy, 32'd0);
        step();
        chk("m2 beat0 busy", busy, 32'd0);
        step();
        chk("m2 stream entry", busy, 32'd1);
        in_valid = 1'b0;
        stream_check("m2", {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd15},
                           {8'd0, 8'd0, 8'd0, 8'd15, 8'd15, 8'd0});

        // Matrix 3 {7,2},{1,9}, reset at frame 2 cycle 7
        step();
        in_valid = 1'b1;
        in_row   = 8'h27;
        step();
        in_row = 8'h91;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 43; i++) step();
        chk("m3 pre-rst frame_idx", frame_idx, 32'd2);
        chk("m3 pre-rst unary", unary_out, 32'd2);
        chk("m3 pre-rst busy", busy, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst unary", unary_out, 32'd0);
        chk("midrst frame_start", frame_start, 32'd0);
        chk("midrst busy", busy, 32'd0);
        chk("midrst done", done, 32'd0);
        chk("midrst in_ready", in_ready, 32'd1);
        chk("midrst frame_idx", frame_idx, 32'd0);
        reset_n = 1'b1;

        // Matrix 4 {2,4},{6,8} after the reset
        in_valid = 1'b1;
        in_row   = 8'h42;
        step();
        in_row = 8'h86;
        step();
        in_valid = 1'b0;
        stream_check("m4", {8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd2},
                           {8'd0, 8'd0, 8'd0, 8'd8, 8'd4, 8'd0});
        step();
        chk("m4 back to load", in_ready, 32'd1);

        // Sweep instance: rows 1,3,2, FRAME_LEN 6, 3 frames, no skew
        sw_in_valid = 1'b1;
        sw_in_row   = 2'd1;
        step();
        sw_in_row = 2'd3;
        step();
        sw_in_row = 2'd2;
        step();
        sw_in_valid = 1'b0;
        sw_fs_cnt = 0;
        sw_bad    = 0;
        for (int a = 0; a < 3; a++) begin
            sw_cnt[a] = 0;
            sw_hi[a]  = 0;
        end
        for (int c = 0; c < 18; c++) begin
            sf = c / 6;
            sk = c % 6;
            if (sw_unary[0] === 1'b1) begin
                sw_cnt[sf]++;
                sw_hi[sf] = sk + 1;
            end
            if (sw_frame_start === 1'b1) sw_fs_cnt++;
            if (sw_frame_start !== (sk == 0)) sw_bad++;
            if (sw_frame_idx !== 2'(sf) || sw_busy !== 1'b1 || sw_done !== 1'b0) sw_bad++;
            step();
        end
        chk("sw f0 ones", sw_cnt[0], 32'd1);
        chk("sw f1 ones", sw_cnt[1], 32'd3);
        chk("sw f2 ones", sw_cnt[2], 32'd2);
        chk("sw f0 run_end", sw_hi[0], 32'd1);
        chk("sw f1 run_end", sw_hi[1], 32'd3);
        chk("sw f2 run_end", sw_hi[2], 32'd2);
        chk("sw frame_start count", sw_fs_cnt, 32'd3);
        chk("sw timing", sw_bad, 32'd0);
        chk("sw done", sw_done, 32'd1);
        chk("sw done busy", sw_busy, 32'd0);
        step();
        chk("sw back to load", sw_in_ready, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
